// File: rtl/commit_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// commit_ctrl_pkg
// Shared constants for the commit stage: ROB index width, datapath width,
// head instruction type encodings and the commit FSM state type.
// -----------------------------------------------------------------------------
package commit_ctrl_pkg;

    localparam int ROB_INDEX_BIT = 4;
    localparam int DATA_W        = 32;

    // Encodings of head_type as produced by the ROB.
    localparam logic [2:0] TYPE_ALU    = 3'd0;
    localparam logic [2:0] TYPE_LOAD   = 3'd1;
    localparam logic [2:0] TYPE_STORE  = 3'd2;
    localparam logic [2:0] TYPE_BRANCH = 3'd3;
    localparam logic [2:0] TYPE_HALT   = 3'd4;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        ST_WAIT = 2'd1,
        FLUSH   = 2'd2,
        HALTED  = 2'd3
    } commit_state_e;

endpackage

// File: rtl/commit_ctrl.sv
// -----------------------------------------------------------------------------
// commit_ctrl
// In-order retirement controller sitting at the ROB head. Retires at most one
// instruction per cycle: register-writing instructions retire combinationally,
// stores wait for the LSB handshake, mispredicted branches trigger a one-cycle
// registered pipeline flush, and HALT parks the block until reset.
//
// Ports
//   clk_in, rst_in          clock, synchronous active-high reset
//   rdy_in                  global stall (low = freeze everything)
//   head_*                  ROB head entry (valid/ready/type/rd/value/id/
//                           mispredict/target PC)
//   pop                     retire the head this cycle (combinational)
//   rf_set_value_id/_value  register file write (id 0 = no write)
//   rf_set_value_rob_id     ROB index of the retiring entry
//   st_commit_req/_ack      store release handshake with the LSB
//   clear, clear_pc         registered flush pulse and refetch PC
//   halt                    sticky end-of-program flag
//   commit_cnt              retired instruction counter (wraps)
// -----------------------------------------------------------------------------
module commit_ctrl
    import commit_ctrl_pkg::*;
(
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     head_valid,
    input  logic                     head_ready,
    input  logic [2:0]               head_type,
    input  logic [4:0]               head_rd,
    input  logic [DATA_W-1:0]        head_value,
    input  logic [ROB_INDEX_BIT-1:0] head_rob_id,
    input  logic                     head_mispred,
    input  logic [DATA_W-1:0]        head_target_pc,
    output logic                     pop,
    output logic [4:0]               rf_set_value_id,
    output logic [DATA_W-1:0]        rf_set_value,
    output logic [ROB_INDEX_BIT-1:0] rf_set_value_rob_id,
    output logic                     st_commit_req,
    input  logic                     st_commit_ack,
    output logic                     clear,
    output logic [DATA_W-1:0]        clear_pc,
    output logic                     halt,
    output logic [31:0]              commit_cnt
);

    commit_state_e     state_q, state_d;
    logic              clear_q, clear_d;
    logic [DATA_W-1:0] clear_pc_q, clear_pc_d;
    logic              st_req_q, st_req_d;
    logic              halt_q, halt_d;
    logic [31:0]       cnt_q, cnt_d;

    // Commit decode and next-state logic. Reset and a low rdy_in both leave
    // every register at its current value and suppress pop / RF writes; the
    // clocked block then applies the reset values.
    always_comb begin
        state_d             = state_q;
        clear_d             = clear_q;
        clear_pc_d          = clear_pc_q;
        st_req_d            = st_req_q;
        halt_d              = halt_q;
        pop                 = 1'b0;
        rf_set_value_id     = 5'd0;
        rf_set_value        = '0;
        rf_set_value_rob_id = '0;

        if (!rst_in && rdy_in) begin
            case (state_q)
                RUN: begin
                    if (head_valid && head_ready) begin
                        case (head_type)
                            TYPE_ALU, TYPE_LOAD, TYPE_BRANCH: begin
                                pop                 = 1'b1;
                                rf_set_value_id     = head_rd;
                                rf_set_value        = head_value;
                                rf_set_value_rob_id = head_rob_id;
                                // The link write still happens now; the flush
                                // pulse follows on the next cycle.
                                if (head_type == TYPE_BRANCH && head_mispred) begin
                                    state_d    = FLUSH;
                                    clear_d    = 1'b1;
                                    clear_pc_d = head_target_pc;
                                end
                            end
                            TYPE_STORE: begin
                                state_d  = ST_WAIT;
                                st_req_d = 1'b1;
                            end
                            TYPE_HALT: begin
                                pop                 = 1'b1;
                                rf_set_value_rob_id = head_rob_id;
                                state_d             = HALTED;
                                halt_d              = 1'b1;
                            end
                            default: ; // unknown encodings are not retired
                        endcase
                    end
                end
                ST_WAIT: begin
                    if (st_commit_ack) begin
                        pop                 = 1'b1;
                        rf_set_value_rob_id = head_rob_id;
                        state_d             = RUN;
                        st_req_d            = 1'b0;
                    end
                end
                FLUSH: begin
                    state_d = RUN;
                    clear_d = 1'b0;
                end
                HALTED: ;
                default: state_d = RUN;
            endcase
        end

        cnt_d = cnt_q + {31'd0, pop};
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= RUN;
            clear_q    <= 1'b0;
            clear_pc_q <= '0;
            st_req_q   <= 1'b0;
            halt_q     <= 1'b0;
            cnt_q      <= 32'd0;
        end else begin
            state_q    <= state_d;
            clear_q    <= clear_d;
            clear_pc_q <= clear_pc_d;
            st_req_q   <= st_req_d;
            halt_q     <= halt_d;
            cnt_q      <= cnt_d;
        end
    end

    assign st_commit_req = st_req_q;
    assign clear         = clear_q;
    assign clear_pc      = clear_pc_q;
    assign halt          = halt_q;
    assign commit_cnt    = cnt_q;

endmodule

// File: tb/tb_commit_ctrl.sv
// -----------------------------------------------------------------------------
// tb_commit_ctrl
// Self-checking bench for commit_ctrl: directed scenarios followed by random
// traffic, all compared against a retirement model kept in the bench.
// -----------------------------------------------------------------------------
module tb_commit_ctrl;
    import commit_ctrl_pkg::*;

    logic                     clk_in = 1'b0;
    logic                     rst_in;
    logic                     rdy_in;
    logic                     head_valid;
    logic                     head_ready;
    logic [2:0]               head_type;
    logic [4:0]               head_rd;
    logic [31:0]              head_value;
    logic [ROB_INDEX_BIT-1:0] head_rob_id;
    logic                     head_mispred;
    logic [31:0]              head_target_pc;
    logic                     pop;
    logic [4:0]               rf_set_value_id;
    logic [31:0]              rf_set_value;
    logic [ROB_INDEX_BIT-1:0] rf_set_value_rob_id;
    logic                     st_commit_req;
    logic                     st_commit_ack;
    logic                     clear;
    logic [31:0]              clear_pc;
    logic                     halt;
    logic [31:0]              commit_cnt;

    commit_ctrl dut (
        .clk_in              (clk_in),
        .rst_in              (rst_in),
        .rdy_in              (rdy_in),
        .head_valid          (head_valid),
        .head_ready          (head_ready),
        .head_type           (head_type),
        .head_rd             (head_rd),
        .head_value          (head_value),
        .head_rob_id         (head_rob_id),
        .head_mispred        (head_mispred),
        .head_target_pc      (head_target_pc),
        .pop                 (pop),
        .rf_set_value_id     (rf_set_value_id),
        .rf_set_value        (rf_set_value),
        .rf_set_value_rob_id (rf_set_value_rob_id),
        .st_commit_req       (st_commit_req),
        .st_commit_ack       (st_commit_ack),
        .clear               (clear),
        .clear_pc            (clear_pc),
        .halt                (halt),
        .commit_cnt          (commit_cnt)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: what the retirement stage is currently doing.
    bit          m_halted;
    bit          m_store_pending;
    bit          m_flush_now;
    logic [31:0] m_refetch_pc;
    logic [31:0] m_retired;

    task automatic check_val(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_halted        = 1'b0;
        m_store_pending = 1'b0;
        m_flush_now     = 1'b0;
        m_refetch_pc    = 32'd0;
        m_retired       = 32'd0;
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, advance.
    task automatic step(input bit r, input bit go, input bit v, input bit hr,
                        input logic [2:0] t, input logic [4:0] rd,
                        input logic [31:0] val, input logic [ROB_INDEX_BIT-1:0] rob,
                        input bit mp, input logic [31:0] tgt, input bit ack);
        bit          e_pop;
        logic [4:0]  e_id;
        bit          nx_halted, nx_store, nx_flush;
        logic [31:0] nx_pc;
        @(negedge clk_in);
        rst_in         = r;
        rdy_in         = go;
        head_valid     = v;
        head_ready     = hr;
        head_type      = t;
        head_rd        = rd;
        head_value     = val;
        head_rob_id    = rob;
        head_mispred   = mp;
        head_target_pc = tgt;
        st_commit_ack  = ack;
        #1;
        e_pop     = 1'b0;
        e_id      = 5'd0;
        nx_halted = m_halted;
        nx_store  = m_store_pending;
        nx_flush  = m_flush_now;
        nx_pc     = m_refetch_pc;
        if (!r && go) begin
            if (m_halted) begin
                // nothing retires after HALT
            end else if (m_flush_now) begin
                nx_flush = 1'b0;
            end else if (m_store_pending) begin
                if (ack) begin
                    e_pop    = 1'b1;
                    nx_store = 1'b0;
                end
            end else if (v && hr) begin
                if (t == 3'd0 || t == 3'd1 || t == 3'd3) begin
                    e_pop = 1'b1;
                    e_id  = rd;
                    if (t == 3'd3 && mp) begin
                        nx_flush = 1'b1;
                        nx_pc    = tgt;
                    end
                end else if (t == 3'd2) begin
                    nx_store = 1'b1;
                end else if (t == 3'd4) begin
                    e_pop     = 1'b1;
                    nx_halted = 1'b1;
                end
            end
        end
        check_val("pop", pop, e_pop);
        check_val("rf_id", rf_set_value_id, e_id);
        if (e_id != 5'd0) check_val("rf_value", rf_set_value, val);
        if (e_pop) check_val("rf_rob_id", rf_set_value_rob_id, rob);
        check_val("st_req", st_commit_req, m_store_pending);
        check_val("clear", clear, m_flush_now);
        check_val("clear_pc", clear_pc, m_refetch_pc);
        check_val("halt", halt, m_halted);
        check_val("commit_cnt", commit_cnt, m_retired);
        @(posedge clk_in);
        if (r) begin
            model_reset();
        end else if (go) begin
            m_halted        = nx_halted;
            m_store_pending = nx_store;
            m_flush_now     = nx_flush;
            m_refetch_pc    = nx_pc;
            if (e_pop) m_retired = m_retired + 32'd1;
        end
    endtask

    task automatic idle(input bit go);
        step(1'b0, go, 1'b0, 1'b0, 3'd0, 5'd0, 32'd0, '0, 1'b0, 32'd0, 1'b0);
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; head_valid = 1'b0; head_ready = 1'b0;
        head_type = 3'd0; head_rd = 5'd0; head_value = 32'd0; head_rob_id = '0;
        head_mispred = 1'b0; head_target_pc = 32'd0; st_commit_ack = 1'b0;
        repeat (2) @(posedge clk_in);
        model_reset();

        // Reset held, with a ready ALU head and ack offered: nothing retires.
        step(1'b1, 1'b1, 1'b1, 1'b1, TYPE_ALU, 5'd3, 32'h33, 4'd1, 1'b0, 32'd0, 1'b1);
        idle(1'b1);

        // Back-to-back ALU retirement.
        step(1'b0, 1'b1, 1'b1, 1'b1, TYPE_ALU, 5'd5, 32'h11, 4'd2, 1'b0, 32'd0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, TYPE_ALU, 5'd6, 32'h22, 4'd3, 1'b0, 32'd0, 1'b0);
        #2 check_val("b2b_cnt", commit_cnt, 32'd2);

        // Stray ack with no store outstanding, head not ready.
        step(1'b0, 1'b1, 1'b1, 1'b0, TYPE_ALU, 5'd7, 32'h77, 4'd4, 1'b0, 32'd0, 1'b1);

        // Store acked three cycles after it reaches the head.
        step(1'b0, 1'b1, 1'b1, 1'b1, TYPE_STORE, 5'd0, 32'h0, 4'd5, 1'b0, 32'd0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, TYPE_STORE, 5'd0, 32'h0, 4'd5, 1'b0, 32'd0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, TYPE_STORE, 5'd0, 32'h0, 4'd5, 1'b0, 32'd0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, TYPE_STORE, 5'd0, 32'h0, 4'd5, 1'b0, 32'd0, 1'b1);
        #2 check_val("store_done_req", st_commit_req, 1'b0);

        // Mispredicted branch with link write.
        step(1'b0, 1'b1, 1'b1, 1'b1, TYPE_BRANCH, 5'd1, 32'h104, 4'd6, 1'b1, 32'h200, 1'b0);
        #2 check_val("flush_clear", clear, 1'b1);
        check_val("flush_pc", clear_pc, 32'h200);
        step(1'b0, 1'b1, 1'b1, 1'b1, TYPE_ALU, 5'd9, 32'h99, 4'd7, 1'b0, 32'd0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, TYPE_ALU, 5'd0, 32'h55, 4'd8, 1'b0, 32'd0, 1'b0);

        // Stall during a store wait while ack is offered.
        step(1'b0, 1'b1, 1'b1, 1'b1, TYPE_STORE, 5'd0, 32'h0, 4'd9, 1'b0, 32'd0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, TYPE_STORE, 5'd0, 32'h0, 4'd9, 1'b0, 32'd0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1, TYPE_STORE, 5'd0, 32'h0, 4'd9, 1'b0, 32'd0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1, TYPE_STORE, 5'd0, 32'h0, 4'd9, 1'b0, 32'd0, 1'b1);

        // Halt, then ready heads must stay, then reset.
        step(1'b0, 1'b1, 1'b1, 1'b1, TYPE_HALT, 5'd0, 32'h0, 4'd10, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 1'b1, 1'b1, TYPE_ALU, 5'd4, 32'h44, 4'd11, 1'b1, 32'h300, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1, TYPE_ALU, 5'd4, 32'h44, 4'd11, 1'b0, 32'd0, 1'b0);
        #2 check_val("post_rst_halt", halt, 1'b0);
        check_val("post_rst_cnt", commit_cnt, 32'd0);
        step(1'b0, 1'b1, 1'b1, 1'b1, TYPE_LOAD, 5'd12, 32'hABCD, 4'd12, 1'b0, 32'd0, 1'b0);

        // Reset while a store is pending and while a flush is pending.
        step(1'b0, 1'b1, 1'b1, 1'b1, TYPE_STORE, 5'd0, 32'h0, 4'd1, 1'b0, 32'd0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, TYPE_STORE, 5'd0, 32'h0, 4'd1, 1'b0, 32'd0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1, TYPE_BRANCH, 5'd2, 32'h8, 4'd2, 1'b1, 32'h400, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, TYPE_ALU, 5'd0, 32'h0, 4'd0, 1'b0, 32'd0, 1'b0);
        idle(1'b1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [2:0] t;
            int         sel;
            sel = $urandom_range(99);
            if (sel < 30)      t = TYPE_ALU;
            else if (sel < 50) t = TYPE_LOAD;
            else if (sel < 70) t = TYPE_STORE;
            else if (sel < 96) t = TYPE_BRANCH;
            else               t = TYPE_HALT;
            step($urandom_range(99) < 3,
                 $urandom_range(99) < 85,
                 $urandom_range(99) < 80,
                 $urandom_range(99) < 75,
                 t,
                 5'($urandom_range(31)),
                 32'($urandom),
                 ROB_INDEX_BIT'($urandom_range((1 << ROB_INDEX_BIT) - 1)),
                 $urandom_range(99) < 40,
                 32'($urandom),
                 $urandom_range(99) < 35);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
